// File: rtl/kmer_extractor.sv
// rtl/kmer_extractor.sv - streams 2-bit bases into a K-base window and records every overlapping K-mer
// Presents all SEQ_LEN-K+1 K-mers as a stable packed block once the sequence is consumed.
module kmer_extractor #(
   parameter  int K         = 16,
   parameter  int SEQ_LEN   = 64,
   localparam int NUM_KMERS = SEQ_LEN - K + 1
) (
   input  logic                              clk,
   input  logic                              rstN,
   input  logic                              start,
   input  logic                              baseValid,
   input  logic [1:0]                        base,
   output logic                              baseReady,
   output logic [NUM_KMERS-1:0][2*K-1:0]     kmers,
   output logic                              kmersValid,
   output logic                              busy
);

   localparam int            CW         = $clog2(SEQ_LEN + 1);
   localparam logic [CW-1:0] FIRST_KMER = CW'(K - 1);
   localparam logic [CW-1:0] LAST_BASE  = CW'(SEQ_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                        r_state;
   state_t                        w_next;
   logic [2*K-1:0]                r_window;
   logic [2*K-1:0]                w_window_next;
   logic [CW-1:0]                 r_base_count;
   logic [CW-1:0]                 w_kmer_idx;
   logic [NUM_KMERS-1:0][2*K-1:0] r_kmers;
   logic                          w_accept;
   logic                          w_clear;
   logic                          w_write;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_clear  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_clear = 1'b1;
               w_next  = S_LOAD;
            end
         end
         S_LOAD: begin
            // start is deliberately ignored here; only bases advance the load
            if (baseValid) begin
               w_accept = 1'b1;
               if (r_base_count == LAST_BASE) begin
                  w_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (start) begin
               w_clear = 1'b1;
               w_next  = S_LOAD;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign w_window_next = {r_window[2*K-3:0], base};
   assign w_kmer_idx    = r_base_count - FIRST_KMER;
   assign w_write       = w_accept && (r_base_count >= FIRST_KMER);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state      <= S_IDLE;
         r_window     <= '0;
         r_base_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_clear) begin
            r_window     <= '0;
            r_base_count <= '0;
         end else if (w_accept) begin
            r_window     <= w_window_next;
            r_base_count <= r_base_count + 1'b1;
         end
      end
   end

   // Index decode by comparison keeps every write provably inside the array
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_kmers <= '0;
      end else if (w_clear) begin
         r_kmers <= '0;
      end else if (w_write) begin
         for (int i = 0; i < NUM_KMERS; i++) begin
            if (w_kmer_idx == CW'(i)) begin
               r_kmers[i] <= w_window_next;
            end
         end
      end
   end

   assign baseReady  = (r_state == S_LOAD);
   assign busy       = (r_state == S_LOAD);
   assign kmersValid = (r_state == S_DONE);
   assign kmers      = r_kmers;

endmodule

// File: tb/tb_kmer_extractor.sv
// tb/tb_kmer_extractor.sv - randomized directed bench for kmer_extractor against an arithmetic K-mer model
module tb_kmer_extractor;

   localparam int K         = 16;
   localparam int SEQ_LEN   = 64;
   localparam int NUM_KMERS = SEQ_LEN - K + 1;

   logic                          clk = 1'b0;
   logic                          rstN;
   logic                          start;
   logic                          baseValid;
   logic [1:0]                    base;
   logic                          baseReady;
   logic [NUM_KMERS-1:0][2*K-1:0] kmers;
   logic                          kmersValid;
   logic                          busy;

   logic [1:0] bases [SEQ_LEN];
   int         checks = 0;
   int         errors = 0;
   int         stalls;

   kmer_extractor #(.K(K), .SEQ_LEN(SEQ_LEN)) dut (
      .clk        (clk),
      .rstN       (rstN),
      .start      (start),
      .baseValid  (baseValid),
      .base       (base),
      .baseReady  (baseReady),
      .kmers      (kmers),
      .kmersValid (kmersValid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // K-mer i is bases i..i+K-1 read as a base-4 number, first base most significant
   function automatic logic [31:0] ref_kmer(input int i);
      logic [63:0] acc = 0;
      for (int j = 0; j < K; j++) acc = acc * 4 + 64'(bases[i + j]);
      return acc[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NUM_KMERS; i++) check($sformatf("%s[%0d]", tag, i), kmers[i], ref_kmer(i));
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < NUM_KMERS; i++) check($sformatf("%s[%0d]", tag, i), kmers[i], 32'h0);
   endtask

   task automatic idle_noise(input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         baseValid = 1'b1;
         base      = 2'($urandom);
         check(tag, {31'b0, baseReady}, 32'h0);
         tick();
      end
      baseValid = 1'b0;
   endtask

   // Feeds bases[0..n-1]; gap_pct injects idle cycles carrying junk, mid_start pulses start with that base
   task automatic feed(input int n, input int gap_pct, input int mid_start_at, output int n_stalls);
      n_stalls = 0;
      for (int i = 0; i < n; i++) begin
         int  budget = 0;
         bit  accepted = 0;
         while (!accepted) begin
            logic rdy;
            if ($urandom_range(99) < gap_pct) begin
               baseValid = 1'b0;
               base      = 2'($urandom);
               n_stalls++;
            end else begin
               baseValid = 1'b1;
               base      = bases[i];
            end
            start = (i == mid_start_at) && baseValid;
            if (i == SEQ_LEN - 1 && baseValid) begin
               check("busy_before_last", {31'b0, busy}, 32'h1);
               check("valid_before_last", {31'b0, kmersValid}, 32'h0);
            end
            rdy = baseReady;
            tick();
            start = 1'b0;
            if (baseValid && rdy) accepted = 1;
            budget++;
            if (budget > 200) begin
               $display("FAIL feed_timeout base=%0d observed=not_accepted expected=accepted", i);
               $fatal(1);
            end
         end
      end
      baseValid = 1'b0;
   endtask

   initial begin
      rstN      = 1'b0;
      start     = 1'b0;
      baseValid = 1'b0;
      base      = 2'b00;

      // Traffic while held in reset must have no effect
      for (int c = 0; c < 4; c++) begin
         start     = 1'($urandom);
         baseValid = 1'($urandom);
         base      = 2'($urandom);
         tick();
         check("rst_ready", {31'b0, baseReady}, 32'h0);
         check("rst_valid", {31'b0, kmersValid}, 32'h0);
         check("rst_busy", {31'b0, busy}, 32'h0);
      end
      check_zero("rst_kmers");
      start = 1'b0;
      baseValid = 1'b0;
      #3 rstN = 1'b1;
      tick();
      tick();
      check("idle_ready", {31'b0, baseReady}, 32'h0);
      idle_noise(3, "idle_noise_ready");

      // Known prefix followed by random bases, back to back
      begin
         logic [1:0] known [16] = '{3,0,1,2,2,0,3,3,2,0,3,3,0,2,0,1};
         for (int i = 0; i < SEQ_LEN; i++) bases[i] = (i < 16) ? known[i] : 2'($urandom);
      end
      pulse_start();
      check("load_ready", {31'b0, baseReady}, 32'h1);
      check("load_busy", {31'b0, busy}, 32'h1);
      check_zero("fresh_kmers");
      feed(SEQ_LEN, 0, -1, stalls);
      check("known_valid", {31'b0, kmersValid}, 32'h1);
      check("known_k0", kmers[0], 32'hC68F8F21);
      check("known_k1", kmers[1], (32'hC68F8F21 << 2) | 32'(bases[16]));
      check_all("known");

      // base_i = i mod 4 with gaps, a start pulse mid-load, and noise in DONE
      for (int i = 0; i < SEQ_LEN; i++) bases[i] = 2'(i % 4);
      pulse_start();
      feed(SEQ_LEN, 30, 30, stalls);
      check("mod4_valid", {31'b0, kmersValid}, 32'h1);
      check("mod4_k0", kmers[0], 32'h1B1B1B1B);
      check("mod4_k1", kmers[1], 32'h6C6C6C6C);
      check("mod4_k48", kmers[48], 32'h1B1B1B1B);
      check_all("mod4");
      idle_noise(4, "done_noise_ready");
      check("done_hold_valid", {31'b0, kmersValid}, 32'h1);
      check_all("done_hold");

      // All-T sequence
      for (int i = 0; i < SEQ_LEN; i++) bases[i] = 2'd3;
      pulse_start();
      feed(SEQ_LEN, 0, -1, stalls);
      for (int i = 0; i < NUM_KMERS; i++) check($sformatf("allT[%0d]", i), kmers[i], 32'hFFFFFFFF);

      // Restart from DONE, then an all-A stream
      pulse_start();
      check("restart_valid", {31'b0, kmersValid}, 32'h0);
      check("restart_busy", {31'b0, busy}, 32'h1);
      check_zero("restart_cleared");
      for (int i = 0; i < SEQ_LEN; i++) bases[i] = 2'd0;
      feed(SEQ_LEN, 20, -1, stalls);
      check("zero_valid", {31'b0, kmersValid}, 32'h1);
      check_zero("zero_kmers");

      // Asynchronous reset mid-load at base 40
      for (int i = 0; i < SEQ_LEN; i++) bases[i] = 2'($urandom);
      pulse_start();
      feed(40, 0, -1, stalls);
      #2 rstN = 1'b0;
      #1;
      check("mid_rst_ready", {31'b0, baseReady}, 32'h0);
      check("mid_rst_valid", {31'b0, kmersValid}, 32'h0);
      check("mid_rst_busy", {31'b0, busy}, 32'h0);
      check_zero("mid_rst_kmers");
      tick();
      rstN = 1'b1;
      tick();
      check("post_rst_ready", {31'b0, baseReady}, 32'h0);

      // Full random sequence with gaps after the reset
      for (int i = 0; i < SEQ_LEN; i++) bases[i] = 2'($urandom);
      pulse_start();
      feed(SEQ_LEN, 25, -1, stalls);
      check("final_valid", {31'b0, kmersValid}, 32'h1);
      check_all("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
